// File: rtl/timer_defs.sv
// Shared definitions for the interval timer: FSM state encodings, register
// word offsets, mode constants and CTRL bit positions.
package timer_defs;

    // FSM states of the count engine.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Register word offsets on the peripheral bus; offset 3 is reserved.
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL.MODE values; 10 and 11 are treated as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM_BIT  = 3;
    localparam int CTRL_PSC_LO  = 8;
    localparam int CTRL_PSC_HI  = 15;

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for the count engine: emits one tick every psc_i+1 clocks
// while run_i is high. Used only when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic [7:0] psc_i,
    output logic [7:0] cnt_o,
    output logic       tick_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // A tick is issued on the clock where the divider reaches the programmed
    // value, so psc_i=0 ticks every clock.
    assign tick_o = (cnt_q == psc_i);
    assign cnt_o  = cnt_q;

    // Next divider value: clear wins, otherwise advance while running and
    // wrap to zero on the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (run_i) begin
            cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

    // Divider register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped interval timer (CTRL / PRESET / COUNT) driving one CP0 HWInt
// line. One-shot mode holds the interrupt until the next CTRL write;
// auto-reload mode emits a one-cycle pulse every PRESET+3 clocks.
// Optional: define TIMER_PRESCALE_EN to add the CTRL[15:8] prescaler field.
module timer_counter
    import timer_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] preset_q;
    logic             en_q;
    logic [1:0]       mode_q;
    logic             im_q;
    logic             flag_q;

    logic ctrl_wr;
    logic preset_wr;
    logic tick;

    // Only the low CTRL bits and CNT_W PRESET bits are stored; the reduction
    // keeps the remaining write-data bits formally consumed.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] psc_q;
    logic [7:0] psc_cnt;
    logic       unused_psc_cnt;

    assign unused_psc_cnt = ^psc_cnt;

    timer_prescaler u_prescaler (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (ctrl_wr || (state_q == ST_LOAD)),
        .run_i   (state_q == ST_CNT),
        .psc_i   (psc_q),
        .cnt_o   (psc_cnt),
        .tick_o  (tick)
    );

    // Prescaler field of CTRL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= 8'd0;
        end else if (ctrl_wr) begin
            psc_q <= wdata[CTRL_PSC_HI:CTRL_PSC_LO];
        end
    end
`else
    // Without the prescaler every CNT-state decision is taken each clock.
    assign tick = 1'b1;
`endif

    // PRESET is only consumed at LOAD, so a write never disturbs a running count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_q <= '0;
        end else if (preset_wr) begin
            preset_q <= wdata[CNT_W-1:0];
        end
    end

    // Count engine FSM plus the CTRL fields it shares with the bus. The bus
    // write is placed last so it overrides the FSM's own EN clear and any
    // flag update made on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            en_q    <= 1'b0;
            mode_q  <= MODE_ONESHOT;
            im_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_q) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_q <= preset_q;
                    state_q <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en_q) begin
                        state_q <= ST_IDLE;
                    end else if (tick) begin
                        if (count_q == '0) begin
                            state_q <= ST_INT;
                            flag_q  <= 1'b1;
                        end else begin
                            count_q <= count_q - CNT_ONE;
                        end
                    end
                end
                ST_INT: begin
                    if (mode_q == MODE_RELOAD) begin
                        flag_q  <= 1'b0;
                        state_q <= ST_LOAD;
                    end else begin
                        en_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (ctrl_wr) begin
                en_q   <= wdata[CTRL_EN_BIT];
                mode_q <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                im_q   <= wdata[CTRL_IM_BIT];
                flag_q <= 1'b0;
            end
        end
    end

    // Interrupt line: the flag gated by the mask, combinational so raising
    // IM exposes an already-set flag at once.
    assign irq = flag_q && im_q;

    // Combinational register read; reserved bits and offset 3 read zero.
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL: begin
                rdata[CTRL_EN_BIT]               = en_q;
                rdata[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
                rdata[CTRL_IM_BIT]               = im_q;
`ifdef TIMER_PRESCALE_EN
                rdata[CTRL_PSC_HI:CTRL_PSC_LO]   = psc_q;
`endif
            end
            ADDR_PRESET: rdata = 32'(preset_q);
            ADDR_COUNT:  rdata = 32'(count_q);
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: bus writes drive the timer, expected
// irq/rdata values are queued when stimulus is applied and compared as the
// DUT produces them.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // Clock: 20 ns period; inputs change and outputs are sampled in the low phase.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected value and compare it with the observation.
    task automatic sb_check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got 0x%08h expected <empty queue>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // Called in the low phase: the write lands on the next rising edge and
    // the task returns in the low phase just after it.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        addr = a;
        #1;
        sb_check(tag, rdata);
    endtask

    task automatic expect_irq(input logic exp, input string tag);
        exp_q.push_back({31'd0, exp});
        #1;
        sb_check(tag, {31'd0, irq});
    endtask

    initial begin
        reset = 1'b0;
        addr  = 2'd0;
        we    = 1'b0;
        wdata = 32'h0;
        step(3);
        reset = 1'b1;
        step(2);

        // ---------------- reset state ----------------
        for (int a = 0; a < 4; a++) begin
            expect_rd(2'(a), 32'h0, $sformatf("rst_rd%0d", a));
        end
        expect_irq(1'b0, "rst_irq");

        // Register file: PRESET readback, read-only COUNT, reserved address,
        // unstored CTRL bits.
        bus_write(2'd1, 32'h0000_ABCD);
        expect_rd(2'd1, 32'h0000_ABCD, "preset_rb");
        bus_write(2'd2, 32'h0000_1234);
        expect_rd(2'd2, 32'h0, "count_ro");
        bus_write(2'd3, 32'hFFFF_FFFF);
        expect_rd(2'd3, 32'h0, "addr3_rd");
        bus_write(2'd0, 32'hFFFF_FFF6);
`ifdef TIMER_PRESCALE_EN
        expect_rd(2'd0, 32'h0000_FF06, "ctrl_rsvd");
`else
        expect_rd(2'd0, 32'h0000_0006, "ctrl_rsvd");
`endif
        bus_write(2'd0, 32'h0);

        // ---------------- one-shot, PRESET=5: irq after edge t+8 ----------------
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        for (int k = 0; k <= 10; k++) exp_q.push_back({31'd0, (k >= 8)});
        for (int k = 0; k <= 10; k++) begin
            #1;
            sb_check($sformatf("os_irq%0d", k), {31'd0, irq});
            if (k < 10) @(negedge clk);
        end
        expect_rd(2'd0, 32'h8, "os_ctrl_en_clr");
        bus_write(2'd0, 32'h8);
        expect_irq(1'b0, "os_irq_clr");
        step(1);
        expect_irq(1'b0, "os_irq_clr2");

        // ---------------- auto-reload, PRESET=2: pulse every 5 clocks ----------------
        addr = 2'd2;
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hB);
        addr = 2'd2;
        for (int k = 0; k <= 20; k++) begin
            int ph;
            ph = (k - 2) % 5;
            exp_q.push_back({31'd0, (k >= 5) && (k % 5 == 0)});
            if (k < 2) exp_q.push_back(32'd0);
            else exp_q.push_back((ph == 0) ? 32'd2 : (ph == 1) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k <= 20; k++) begin
            #1;
            sb_check($sformatf("ar_irq%0d", k), {31'd0, irq});
            sb_check($sformatf("ar_cnt%0d", k), rdata);
            @(negedge clk);
        end
        bus_write(2'd0, 32'h0);
        step(5);
        expect_irq(1'b0, "ar_stop_irq");

        // ---------------- masking, PRESET=0 ----------------
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h1);
        for (int k = 0; k <= 6; k++) begin
            expect_irq(1'b0, $sformatf("mask_irq%0d", k));
            if (k < 6) @(negedge clk);
        end
        expect_rd(2'd0, 32'h0, "mask_ctrl");
        bus_write(2'd0, 32'h8);
        expect_irq(1'b0, "mask_clr_irq");
        expect_rd(2'd0, 32'h8, "mask_ctrl_im");
        step(2);
        expect_irq(1'b0, "mask_clr_irq2");
        bus_write(2'd0, 32'h9);
        for (int k = 0; k <= 6; k++) exp_q.push_back({31'd0, (k >= 3)});
        for (int k = 0; k <= 6; k++) begin
            #1;
            sb_check($sformatf("unmask_irq%0d", k), {31'd0, irq});
            if (k < 6) @(negedge clk);
        end
        bus_write(2'd0, 32'h8);
        expect_irq(1'b0, "unmask_clr");

        // ---------------- mid-count disable, then PRESET change ----------------
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        step(6);
        expect_rd(2'd2, 32'd6, "mid_cnt6");
        bus_write(2'd0, 32'h0);
        expect_rd(2'd2, 32'd5, "mid_cnt_last");
        for (int k = 0; k < 4; k++) begin
            step(1);
            expect_rd(2'd2, 32'd5, $sformatf("mid_frozen%0d", k));
            expect_irq(1'b0, $sformatf("mid_irq%0d", k));
        end
        bus_write(2'd1, 32'd3);
        expect_rd(2'd2, 32'd5, "mid_preset_nochg");
        bus_write(2'd0, 32'h9);
        for (int k = 0; k <= 8; k++) exp_q.push_back({31'd0, (k >= 6)});
        for (int k = 0; k <= 8; k++) begin
            #1;
            sb_check($sformatf("reen_irq%0d", k), {31'd0, irq});
            if (k < 8) @(negedge clk);
        end

        // ---------------- reset during count ----------------
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        step(8);
        expect_rd(2'd2, 32'd4, "rstm_cnt4");
        #2;
        reset = 1'b0;
        expect_rd(2'd2, 32'd0, "rstm_count");
        expect_rd(2'd0, 32'd0, "rstm_ctrl");
        expect_rd(2'd1, 32'd0, "rstm_preset");
        expect_irq(1'b0, "rstm_irq");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            expect_rd(2'd2, 32'd0, $sformatf("rstr_count%0d", k));
            expect_rd(2'd0, 32'd0, $sformatf("rstr_ctrl%0d", k));
            expect_irq(1'b0, $sformatf("rstr_irq%0d", k));
        end

        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
